// File: rtl/vga_char_feeder_if.sv
// Character/clear strobe bus between the character feeder and the 40x24 vga block.
// The feeder drives every signal (master); the vga block only observes (slave).
interface vga_char_feeder_if;
    logic       vga_address;
    logic       vga_enable;
    logic       vga_w_en;
    logic [7:0] vga_din;
    logic       vga_clr_screen;

    modport master (output vga_address, vga_enable, vga_w_en, vga_din, vga_clr_screen);
    modport slave  (input  vga_address, vga_enable, vga_w_en, vga_din, vga_clr_screen);
endinterface

// File: rtl/vga_char_feeder.sv
// Buffers CPU display-register writes in a small FIFO and replays them to the vga block
// as paced enable/w_en strobes: strobes high with address 0, then both low with address
// still 0, then address back to 1 before the next character. Also sequences a
// full-frame clear-screen pulse that flushes any queued characters.
module vga_char_feeder #(
    parameter int DEPTH_LOG2  = 4,
    parameter int HOLD_CYCLES = 2,
    parameter int GAP_CYCLES  = 2,
    parameter int CLR_CYCLES  = 416800
) (
    input  logic                  clk25,
    input  logic                  rst_n,
    input  logic                  cpu_wr,
    input  logic [7:0]            cpu_din,
    input  logic                  cpu_clr,
    output logic                  busy,
    output logic                  overflow,
    output logic [DEPTH_LOG2:0]   fifo_level,
    vga_char_feeder_if.master     vga
);

    localparam int DEPTH  = 1 << DEPTH_LOG2;
    localparam int CLR_W  = $clog2(CLR_CYCLES + 1);
    localparam int PH_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int PH_W   = $clog2(PH_MAX + 1);
    localparam logic [DEPTH_LOG2:0] FULL_LEVEL = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, STROBE, GAP, CLEAR} state_t;

    state_t                 state;
    logic [PH_W-1:0]        ph_cnt;
    logic [CLR_W-1:0]       clr_cnt;
    logic [7:0]             mem [DEPTH];
    logic [DEPTH_LOG2-1:0]  wr_ptr;
    logic [DEPTH_LOG2-1:0]  rd_ptr;
    logic [DEPTH_LOG2:0]    level_next;
    logic                   full;
    logic                   empty;
    logic                   push;
    logic                   pop;
    logic                   clear_next;

    // A clear request overrides both FIFO ports, so a byte written alongside it is lost.
    assign full       = (fifo_level == FULL_LEVEL);
    assign empty      = (fifo_level == '0);
    assign push       = cpu_wr && !full && !cpu_clr;
    assign pop        = (state == IDLE) && !empty && !cpu_clr;
    assign clear_next = cpu_clr || ((state == CLEAR) && (clr_cnt != CLR_W'(1)));

    // Next FIFO occupancy; a simultaneous push and pop leaves it unchanged.
    always_comb begin
        // NOTE: default first so every path assigns level_next and no latch is inferred.
        level_next = fifo_level;
        if (cpu_clr)
            level_next = '0;
        else if (push && !pop)
            level_next = fifo_level + (DEPTH_LOG2 + 1)'(1);
        else if (pop && !push)
            level_next = fifo_level - (DEPTH_LOG2 + 1)'(1);
    end

    // Character storage; contents are only meaningful between the pointers.
    // NOTE: the array has no reset -- the pointers and level define validity, and a
    // resettable array would turn cheap RAM into a bank of flops.
    always_ff @(posedge clk25) begin
        if (push)
            mem[wr_ptr] <= cpu_din;
    end

    // FIFO pointers, occupancy, sticky overflow and the registered busy flag.
    always_ff @(posedge clk25 or negedge rst_n) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            overflow   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            if (cpu_clr) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                overflow <= 1'b0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
                if (pop)
                    rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
                if (cpu_wr && full)
                    overflow <= 1'b1;
            end
            fifo_level <= level_next;
            busy       <= (level_next == FULL_LEVEL) || clear_next;
        end
    end

    // Strobe/clear sequencer with outputs registered alongside the state.
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            state              <= IDLE;
            ph_cnt             <= '0;
            clr_cnt            <= '0;
            vga.vga_address    <= 1'b1;
            vga.vga_enable     <= 1'b0;
            vga.vga_w_en       <= 1'b0;
            vga.vga_din        <= 8'h00;
            vga.vga_clr_screen <= 1'b0;
        end else if (cpu_clr) begin
            // Any strobe in flight is abandoned; a clear during CLEAR restarts the count.
            state              <= CLEAR;
            clr_cnt            <= CLR_W'(CLR_CYCLES);
            ph_cnt             <= '0;
            vga.vga_address    <= 1'b1;
            vga.vga_enable     <= 1'b0;
            vga.vga_w_en       <= 1'b0;
            vga.vga_clr_screen <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (!empty) begin
                        state           <= STROBE;
                        ph_cnt          <= PH_W'(HOLD_CYCLES);
                        vga.vga_din     <= mem[rd_ptr];
                        vga.vga_address <= 1'b0;
                        vga.vga_enable  <= 1'b1;
                        vga.vga_w_en    <= 1'b1;
                    end
                end
                STROBE: begin
                    if (ph_cnt == PH_W'(1)) begin
                        state          <= GAP;
                        ph_cnt         <= PH_W'(GAP_CYCLES);
                        vga.vga_enable <= 1'b0;
                        vga.vga_w_en   <= 1'b0;
                    end else begin
                        ph_cnt <= ph_cnt - PH_W'(1);
                    end
                end
                GAP: begin
                    if (ph_cnt == PH_W'(1)) begin
                        state           <= IDLE;
                        vga.vga_address <= 1'b1;
                    end else begin
                        ph_cnt <= ph_cnt - PH_W'(1);
                    end
                end
                CLEAR: begin
                    if (clr_cnt == CLR_W'(1)) begin
                        state              <= IDLE;
                        vga.vga_clr_screen <= 1'b0;
                    end else begin
                        clr_cnt <= clr_cnt - CLR_W'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vga_char_feeder.sv
// Self-checking bench for vga_char_feeder. A queue-based reference model tracks the
// characters and a per-character slot timer; directed scenarios add hard-coded timing.
module tb_vga_char_feeder;

    localparam int DEPTH_LOG2  = 4;
    localparam int DEPTH       = 1 << DEPTH_LOG2;
    localparam int HOLD_CYCLES = 2;
    localparam int GAP_CYCLES  = 2;
    localparam int CLR_CYCLES  = 16;
    localparam int PERIOD      = 1 + HOLD_CYCLES + GAP_CYCLES;
    localparam int DRAIN       = CLR_CYCLES + (DEPTH + 2) * PERIOD + 4;

    logic                clk25 = 1'b0;
    logic                rst_n = 1'b0;
    logic                cpu_wr = 1'b0;
    logic [7:0]          cpu_din = 8'h00;
    logic                cpu_clr = 1'b0;
    logic                busy;
    logic                overflow;
    logic [DEPTH_LOG2:0] fifo_level;

    vga_char_feeder_if vga ();

    vga_char_feeder #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .HOLD_CYCLES(HOLD_CYCLES),
        .GAP_CYCLES (GAP_CYCLES),
        .CLR_CYCLES (CLR_CYCLES)
    ) dut (
        .clk25     (clk25),
        .rst_n     (rst_n),
        .cpu_wr    (cpu_wr),
        .cpu_din   (cpu_din),
        .cpu_clr   (cpu_clr),
        .busy      (busy),
        .overflow  (overflow),
        .fifo_level(fifo_level),
        .vga       (vga)
    );

    always #20 clk25 = ~clk25;

    int errors = 0;
    int checks = 0;
    int cycle  = 0;

    // Reference model: queued bytes, sticky overflow, remaining clear cycles and the
    // position inside the current character slot (-1 when no character is in flight).
    byte unsigned m_q[$];
    logic         m_ovf;
    int           m_clr_left;
    int           m_slot;
    logic [7:0]   m_din;

    byte unsigned m_sent[$];
    byte unsigned d_sent[$];
    int           rise_cyc[$];
    logic         prev_en;

    int           trace_bad;
    int           trace_cyc;
    logic [18:0]  trace_obs;
    logic [18:0]  trace_exp;

    task automatic model_reset();
        m_q.delete();
        m_ovf      = 1'b0;
        m_clr_left = 0;
        m_slot     = -1;
        m_din      = 8'h00;
        prev_en    = 1'b0;
    endtask

    task automatic clear_logs();
        m_sent.delete();
        d_sent.delete();
        rise_cyc.delete();
        trace_bad = 0;
    endtask

    task automatic model_edge(input logic wr, input logic [7:0] din, input logic clr);
        bit full_pre;
        full_pre = (m_q.size() == DEPTH);
        if (clr) begin
            m_q.delete();
            m_ovf      = 1'b0;
            m_clr_left = CLR_CYCLES;
            m_slot     = -1;
        end else begin
            if (m_clr_left > 0) begin
                m_clr_left--;
            end else if (m_slot >= 0) begin
                m_slot++;
                if (m_slot == HOLD_CYCLES + GAP_CYCLES)
                    m_slot = -1;
            end else if (m_q.size() != 0) begin
                m_din  = m_q.pop_front();
                m_sent.push_back(m_din);
                m_slot = 0;
            end
            if (wr) begin
                if (full_pre) m_ovf = 1'b1;
                else          m_q.push_back(din);
            end
        end
    endtask

    function automatic logic [18:0] exp_vec();
        logic clr, en, addr;
        clr  = (m_clr_left > 0);
        en   = !clr && (m_slot >= 0) && (m_slot < HOLD_CYCLES);
        addr = clr || (m_slot < 0);
        return {(m_q.size() == DEPTH) || clr, m_ovf, (DEPTH_LOG2 + 1)'(m_q.size()),
                addr, en, en, m_din, clr};
    endfunction

    function automatic logic [18:0] obs_vec();
        return {busy, overflow, fifo_level, vga.vga_address, vga.vga_enable, vga.vga_w_en,
                vga.vga_din, vga.vga_clr_screen};
    endfunction

    // One clock: drive inputs, advance the model on the edge, observe on the falling edge.
    task automatic step(input logic wr, input logic [7:0] din, input logic clr);
        cpu_wr  = wr;
        cpu_din = din;
        cpu_clr = clr;
        @(posedge clk25);
        model_edge(wr, din, clr);
        @(negedge clk25);
        cpu_wr  = 1'b0;
        cpu_clr = 1'b0;
        cycle++;
        if (vga.vga_enable && !prev_en) begin
            d_sent.push_back(vga.vga_din);
            rise_cyc.push_back(cycle);
        end
        prev_en = vga.vga_enable;
        if (obs_vec() !== exp_vec()) begin
            if (trace_bad == 0) begin
                trace_cyc = cycle;
                trace_obs = obs_vec();
                trace_exp = exp_vec();
            end
            trace_bad++;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_reset();
        logic [18:0] rst_vec;
        rst_vec = {1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};
        clear_logs();
        checks++;
        if (obs_vec() !== rst_vec) begin
            errors++;
            $display("FAIL reset_init: got %h expected %h", obs_vec(), rst_vec);
        end
        step(1'b1, 8'h5A, 1'b0);
        step(1'b1, 8'h33, 1'b0);
        step(1'b1, 8'h44, 1'b0);
        checks++;
        if (vga.vga_enable !== 1'b1) begin
            errors++;
            $display("FAIL reset_pre_strobe: enable got %b expected 1", vga.vga_enable);
        end
        rst_n = 1'b0;
        #5;
        model_reset();
        checks++;
        if (obs_vec() !== rst_vec) begin
            errors++;
            $display("FAIL reset_mid_strobe: got %h expected %h", obs_vec(), rst_vec);
        end
        @(negedge clk25);
        rst_n = 1'b1;
        idle(4);
        checks++;
        if (trace_bad !== 0) begin
            errors++;
            $display("FAIL reset_trace: %0d cycles off, first cycle %0d got %h expected %h",
                     trace_bad, trace_cyc, trace_obs, trace_exp);
        end
    endtask

    task automatic test_single();
        logic       exp_addr [6];
        logic       exp_en   [6];
        exp_addr = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        exp_en   = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        clear_logs();
        for (int k = 0; k < 6; k++) begin
            if (k == 0) step(1'b1, 8'hC1, 1'b0);
            else        step(1'b0, 8'h00, 1'b0);
            checks++;
            if ({vga.vga_address, vga.vga_enable, vga.vga_w_en} !== {exp_addr[k], exp_en[k], exp_en[k]}
                || (k > 0 && vga.vga_din !== 8'hC1)) begin
                errors++;
                $display("FAIL single_k%0d: addr/en/wen/din got %b%b%b/%h expected %b%b%b/c1",
                         k, vga.vga_address, vga.vga_enable, vga.vga_w_en, vga.vga_din,
                         exp_addr[k], exp_en[k], exp_en[k]);
            end
        end
        checks++;
        if (trace_bad !== 0) begin
            errors++;
            $display("FAIL single_trace: %0d cycles off, first cycle %0d got %h expected %h",
                     trace_bad, trace_cyc, trace_obs, trace_exp);
        end
    endtask

    // A 20-write burst is absorbed exactly by the concurrent drain, so 24 forces drops.
    task automatic test_burst();
        bit saw_full;
        int busy_bad, gap_bad, seq_bad;
        saw_full = 0;
        busy_bad = 0;
        gap_bad  = 0;
        seq_bad  = 0;
        clear_logs();
        for (int i = 0; i < 24; i++) begin
            step(1'b1, 8'($urandom), 1'b0);
            if (int'(fifo_level) == DEPTH) begin
                saw_full = 1;
                if (busy !== 1'b1) busy_bad++;
            end
        end
        checks++;
        if (!saw_full || busy_bad != 0) begin
            errors++;
            $display("FAIL burst_busy: saw_full=%0d busy_low_cycles=%0d expected 1/0", saw_full, busy_bad);
        end
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL burst_overflow: got %b expected 1", overflow);
        end
        idle(DRAIN);
        for (int i = 1; i < rise_cyc.size(); i++)
            if (rise_cyc[i] - rise_cyc[i-1] != PERIOD) gap_bad++;
        checks++;
        if (gap_bad != 0) begin
            errors++;
            $display("FAIL burst_spacing: %0d gaps differ from %0d cycles", gap_bad, PERIOD);
        end
        foreach (m_sent[i])
            if (i >= d_sent.size() || d_sent[i] != m_sent[i]) seq_bad++;
        checks++;
        if (seq_bad != 0 || d_sent.size() != m_sent.size()) begin
            errors++;
            $display("FAIL burst_order: got %0d chars (%0d wrong) expected %0d",
                     d_sent.size(), seq_bad, m_sent.size());
        end
        checks++;
        if ({busy, fifo_level} !== 6'd0 || trace_bad !== 0) begin
            errors++;
            $display("FAIL burst_trace: busy/level %b/%0d expected 0/0, %0d cycles off, first cycle %0d got %h expected %h",
                     busy, fifo_level, trace_bad, trace_cyc, trace_obs, trace_exp);
        end
    endtask

    task automatic test_push_pop();
        byte unsigned exp_seq [5];
        int seq_bad;
        exp_seq = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
        seq_bad = 0;
        clear_logs();
        for (int i = 0; i < 4; i++) step(1'b1, exp_seq[i], 1'b0);
        idle(2);
        checks++;
        if (fifo_level !== 5'd3 || vga.vga_address !== 1'b1) begin
            errors++;
            $display("FAIL pushpop_pre: level/addr got %0d/%b expected 3/1", fifo_level, vga.vga_address);
        end
        step(1'b1, exp_seq[4], 1'b0);
        checks++;
        if (fifo_level !== 5'd3 || vga.vga_enable !== 1'b1 || vga.vga_din !== 8'hA1) begin
            errors++;
            $display("FAIL pushpop_same_cycle: level/en/din got %0d/%b/%h expected 3/1/a1",
                     fifo_level, vga.vga_enable, vga.vga_din);
        end
        idle(DRAIN);
        foreach (exp_seq[i])
            if (i >= d_sent.size() || d_sent[i] != exp_seq[i]) seq_bad++;
        checks++;
        if (seq_bad != 0 || d_sent.size() != 5) begin
            errors++;
            $display("FAIL pushpop_order: got %0d chars (%0d wrong) expected 5", d_sent.size(), seq_bad);
        end
    endtask

    task automatic test_clear_gap();
        int hi, busy_bad;
        hi = 0;
        busy_bad = 0;
        clear_logs();
        for (int i = 0; i < 7; i++) step(1'b1, 8'(8'h10 + i), 1'b0);
        idle(2);
        checks++;
        if (fifo_level !== 5'd5 || vga.vga_address !== 1'b0 || vga.vga_enable !== 1'b0) begin
            errors++;
            $display("FAIL clrgap_pre: level/addr/en got %0d/%b/%b expected 5/0/0",
                     fifo_level, vga.vga_address, vga.vga_enable);
        end
        step(1'b0, 8'h00, 1'b1);
        d_sent.delete();
        checks++;
        if ({busy, overflow, fifo_level, vga.vga_address, vga.vga_enable, vga.vga_w_en, vga.vga_clr_screen}
            !== {1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL clrgap_entry: busy/ovf/level/addr/en/wen/clr got %b/%b/%0d/%b/%b/%b/%b expected 1/0/0/1/0/0/1",
                     busy, overflow, fifo_level, vga.vga_address, vga.vga_enable, vga.vga_w_en, vga.vga_clr_screen);
        end
        hi = 1;
        for (int i = 0; i < CLR_CYCLES + 4; i++) begin
            step(1'b0, 8'h00, 1'b0);
            if (vga.vga_clr_screen === 1'b1) begin
                hi++;
                if (busy !== 1'b1) busy_bad++;
            end
        end
        checks++;
        if (hi != CLR_CYCLES || busy_bad != 0) begin
            errors++;
            $display("FAIL clrgap_pulse: clr high %0d cycles (busy low %0d) expected %0d (0)", hi, busy_bad, CLR_CYCLES);
        end
        idle(2 * PERIOD);
        checks++;
        if (d_sent.size() != 0 || busy !== 1'b0 || vga.vga_address !== 1'b1 || trace_bad !== 0) begin
            errors++;
            $display("FAIL clrgap_after: chars %0d busy %b addr %b expected 0/0/1, %0d cycles off model",
                     d_sent.size(), busy, vga.vga_address, trace_bad);
        end
    endtask

    task automatic test_clear_wr();
        clear_logs();
        step(1'b1, 8'h8D, 1'b1);
        checks++;
        if (fifo_level !== 5'd0 || vga.vga_clr_screen !== 1'b1) begin
            errors++;
            $display("FAIL clrwr_entry: level/clr got %0d/%b expected 0/1", fifo_level, vga.vga_clr_screen);
        end
        idle(CLR_CYCLES + 2 * PERIOD);
        checks++;
        if (d_sent.size() != 0 || fifo_level !== 5'd0) begin
            errors++;
            $display("FAIL clrwr_discard: chars %0d level %0d expected 0/0", d_sent.size(), fifo_level);
        end
        // Writes during CLEAR queue up and are released once the clear ends.
        step(1'b0, 8'h00, 1'b1);
        step(1'b1, 8'h77, 1'b0);
        step(1'b1, 8'h78, 1'b0);
        checks++;
        if (fifo_level !== 5'd2 || vga.vga_clr_screen !== 1'b1) begin
            errors++;
            $display("FAIL clrwr_queue: level/clr got %0d/%b expected 2/1", fifo_level, vga.vga_clr_screen);
        end
        idle(DRAIN);
        checks++;
        if (d_sent.size() != 2 || (d_sent.size() == 2 && (d_sent[0] != 8'h77 || d_sent[1] != 8'h78))
            || trace_bad !== 0) begin
            errors++;
            $display("FAIL clrwr_release: got %0d chars expected 77,78; %0d cycles off model",
                     d_sent.size(), trace_bad);
        end
    endtask

    task automatic test_random();
        int seq_bad;
        logic wr, clr;
        seq_bad = 0;
        clear_logs();
        for (int i = 0; i < 800; i++) begin
            wr  = ($urandom_range(0, 99) < 55);
            clr = ($urandom_range(0, 199) == 0);
            step(wr, 8'($urandom), clr);
        end
        idle(DRAIN);
        foreach (m_sent[i])
            if (i >= d_sent.size() || d_sent[i] != m_sent[i]) seq_bad++;
        checks++;
        if (seq_bad != 0 || d_sent.size() != m_sent.size()) begin
            errors++;
            $display("FAIL random_order: got %0d chars (%0d wrong) expected %0d",
                     d_sent.size(), seq_bad, m_sent.size());
        end
        checks++;
        if (trace_bad !== 0) begin
            errors++;
            $display("FAIL random_trace: %0d cycles off, first cycle %0d got %h expected %h",
                     trace_bad, trace_cyc, trace_obs, trace_exp);
        end
    endtask

    initial begin
        model_reset();
        clear_logs();
        repeat (3) @(negedge clk25);
        rst_n = 1'b1;
        test_reset();
        test_single();
        test_burst();
        test_push_pop();
        test_clear_gap();
        test_clear_wr();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
